// File: rtl/pipe_field.sv
// pipe_field: scrolling obstacle field for the flappy game (pipe positions, gap heights, score, speed).
// Latency: registered outputs, updated one clk after a frame_tick edge; no combinational input-to-output path.
// Backpressure: none; motion is gated by frame_tick and game_state. Optional macro PIPE_SPEED_RAMP_EN enables speed ramp.
module pipe_field #(
  parameter int NUM_PIPES     = 4,
  parameter int COORD_W       = 32,
  parameter int PIPE_WIDTH    = 78,
  parameter int PIPE_SPACING  = 180,
  parameter int X_FIRST       = 660,
  parameter int Y_CENTRE      = 210,
  parameter int RAND_W        = 5,
  parameter int RAND_SHIFT    = 1,
  parameter int SCORE_W       = 16,
  parameter int BASE_SPEED    = 1,
  parameter int MAX_SPEED     = 4,
  parameter int RAMP_INTERVAL = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_tick,
  input  logic [3:0]                     game_state,
  input  logic [COORD_W-1:0]             bird_x,
  output logic [NUM_PIPES*COORD_W-1:0]   pipe_x,
  output logic [NUM_PIPES*COORD_W-1:0]   pipe_y,
  output logic [SCORE_W-1:0]             score,
  output logic                           pass_pulse,
  output logic [3:0]                     speed
);

  localparam logic [15:0]               LFSR_SEED = 16'hACE1;
  // Galois feedback mask for taps 16,14,13,11
  localparam logic [15:0]               LFSR_MASK = 16'hB400;
  localparam logic signed [COORD_W-1:0] ZERO      = '0;
  localparam logic signed [COORD_W-1:0] W_C       = COORD_W'(PIPE_WIDTH);
  localparam logic signed [COORD_W-1:0] SP_C      = COORD_W'(PIPE_SPACING);
  localparam logic signed [COORD_W-1:0] YC_C      = COORD_W'(Y_CENTRE);
  localparam logic [3:0]                BASE_SPD  = 4'(BASE_SPEED);

  localparam logic [3:0] ST_START = 4'b0001;
  localparam logic [3:0] ST_GAME  = 4'b0010;

  logic [15:0]               lfsr;
  logic signed [COORD_W-1:0] px       [NUM_PIPES];
  logic signed [COORD_W-1:0] py       [NUM_PIPES];
  logic signed [COORD_W-1:0] moved    [NUM_PIPES];
  logic signed [COORD_W-1:0] px_nxt   [NUM_PIPES];
  logic signed [COORD_W-1:0] py_nxt   [NUM_PIPES];
  logic [NUM_PIPES-1:0]      recyc;
  logic [NUM_PIPES-1:0]      passed;
  logic [SCORE_W-1:0]        score_q;
  logic [SCORE_W-1:0]        score_nxt;
  logic [SCORE_W:0]          score_sum;
  logic [3:0]                speed_q;
  logic signed [COORD_W-1:0] spd_ext;
  logic signed [COORD_W-1:0] bx;
  logic signed [RAND_W-1:0]  rnd;
  logic signed [COORD_W-1:0] rnd_ext;
  logic signed [COORD_W-1:0] new_y;
  logic                      st_start;
  logic                      st_game;
  logic                      any_pass;

  assign st_start = (game_state == ST_START);
  assign st_game  = (game_state == ST_GAME);
  assign bx       = signed'(bird_x);
  assign spd_ext  = signed'({{(COORD_W-4){1'b0}}, speed_q});
  assign rnd      = signed'(lfsr[RAND_W-1:0]);
  assign rnd_ext  = COORD_W'(rnd);
  assign new_y    = YC_C + (rnd_ext <<< RAND_SHIFT);
  assign any_pass = |passed;

  // Pack the per-pipe registers onto the flat output buses
  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
    assign pipe_x[g*COORD_W +: COORD_W] = px[g];
    assign pipe_y[g*COORD_W +: COORD_W] = py[g];
  end

  assign score = score_q;
  assign speed = speed_q;

  // LFSR free-runs every clk so the gap sequence depends on how long the player waited
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    end
  end

  // Next-tick pipe positions, recycle decisions, pass detection and saturating score
  always_comb begin
    score_sum = {1'b0, score_q};
    for (int i = 0; i < NUM_PIPES; i++) begin
      moved[i] = px[i] - spd_ext;
      recyc[i] = ((px[i] + W_C) <= ZERO);
    end
    for (int i = 0; i < NUM_PIPES; i++) begin
      // Recycled pipe lands exactly one pitch behind its predecessor's new position
      if (recyc[i]) begin
        px_nxt[i] = moved[(i + NUM_PIPES - 1) % NUM_PIPES] + SP_C;
        py_nxt[i] = new_y;
      end else begin
        px_nxt[i] = moved[i];
        py_nxt[i] = py[i];
      end
      passed[i] = !recyc[i] && ((px[i] + W_C) >= bx) && ((moved[i] + W_C) < bx);
      if (passed[i]) begin
        score_sum = score_sum + 1'b1;
      end
    end
    score_nxt = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  // Pipe and score state: reload on START_SCREEN ticks, advance on IN_GAME ticks, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        px[i] <= COORD_W'(X_FIRST + i * PIPE_SPACING);
        py[i] <= YC_C;
      end
      score_q <= '0;
    end else if (frame_tick) begin
      if (st_start) begin
        for (int i = 0; i < NUM_PIPES; i++) begin
          px[i] <= COORD_W'(X_FIRST + i * PIPE_SPACING);
          py[i] <= YC_C;
        end
        score_q <= '0;
      end else if (st_game) begin
        for (int i = 0; i < NUM_PIPES; i++) begin
          px[i] <= px_nxt[i];
          py[i] <= py_nxt[i];
        end
        score_q <= score_nxt;
      end
    end
  end

  // One-clk pass strobe; drops on the following edge whether or not a tick arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_pulse <= 1'b0;
    end else begin
      pass_pulse <= frame_tick && st_game && any_pass;
    end
  end

`ifdef PIPE_SPEED_RAMP_EN
  localparam int         RC_W    = $clog2(RAMP_INTERVAL + 1);
  localparam logic [3:0] MAX_SPD = 4'(MAX_SPEED);
  logic [RC_W-1:0] ramp_cnt;

  // Every RAMP_INTERVAL passes bump speed by one up to the ceiling; takes effect next tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_cnt <= '0;
      speed_q  <= BASE_SPD;
    end else if (frame_tick) begin
      if (st_start) begin
        ramp_cnt <= '0;
        speed_q  <= BASE_SPD;
      end else if (st_game && any_pass) begin
        if (ramp_cnt == RC_W'(RAMP_INTERVAL - 1)) begin
          ramp_cnt <= '0;
          if (speed_q < MAX_SPD) begin
            speed_q <= speed_q + 4'd1;
          end
        end else begin
          ramp_cnt <= ramp_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign speed_q = BASE_SPD;
`endif

endmodule

// File: doc/pipe_field.md
Name: pipe_field

Overview:
Parametrised obstacle-field generator for the flappy game. It scrolls NUM_PIPES pipes leftward at a programmable speed and recycles each off-screen pipe behind its predecessor with a new pseudo-random gap height. It also detects when the bird clears a pipe, keeps the score, and optionally ramps scroll speed with score. It sits between the game FSM (game_state) and the renderer/collision logic, and runs on the system clock with a one-cycle frame_tick enable.

Parameters:
NUM_PIPES, 4, number of pipes (>=2)
COORD_W, 32, signed coordinate width
PIPE_WIDTH, 78, pipe width in pixels
PIPE_SPACING, 180, left-edge pitch between consecutive pipes
X_FIRST, 660, reset x of pipe 0
Y_CENTRE, 210, nominal gap centre
RAND_W, 5, signed random offset width
RAND_SHIFT, 1, left shift applied to random offset
SCORE_W, 16, score width
BASE_SPEED, 1, pixels per frame at start
MAX_SPEED, 4, speed ceiling (ramp only)
RAMP_INTERVAL, 8, passes per speed step (ramp only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle frame strobe; all motion happens only on ticks
game_state  in  4  one-hot: 0001 START_SCREEN, 0010 IN_GAME, 0100 PAUSE, 1000 END_SCREEN
bird_x  in  COORD_W  bird left-edge x (signed)
pipe_x  out  NUM_PIPES*COORD_W  packed signed x, pipe i at bits [i*COORD_W +: COORD_W]
pipe_y  out  NUM_PIPES*COORD_W  packed signed gap centre, same packing
score  out  SCORE_W  pipes passed, saturating
pass_pulse  out  1  one-cycle pulse per scoring tick
speed  out  4  current scroll speed

Behaviour:
- rst_n low (async, immediate, also mid-game): pipe_x[i]=X_FIRST+i*PIPE_SPACING; pipe_y[i]=Y_CENTRE; score=0; speed=BASE_SPEED; pass_pulse=0; LFSR=16'hACE1.
- LFSR: 16-bit Galois, taps 16,14,13,11. Advances every clk, independent of frame_tick. rand = signed lfsr[RAND_W-1:0]. New gap y = Y_CENTRE + (sign-extended rand <<< RAND_SHIFT). Defaults give range 178..240.
- All other registers update only on a clk edge with frame_tick=1. Outputs are registered; there is no combinational path from inputs.
- START_SCREEN tick: reload reset x/y, score=0, speed=BASE_SPEED.
- IN_GAME tick, per pipe i:
  - If pipe_x[i]+PIPE_WIDTH<=0 (current value): recycle. pipe_x[i] = (pred's post-tick x) + PIPE_SPACING, where pred=(i+NUM_PIPES-1)%NUM_PIPES. pipe_y[i] = new random y. This keeps the pitch exact.
  - Else pipe_x[i] -= speed.
- PAUSE, END_SCREEN, or any non-one-hot value: hold everything. pass_pulse=0.
- Pass: pipe i passes on a tick where old pipe_x+PIPE_WIDTH >= bird_x and new pipe_x+PIPE_WIDTH < bird_x. score += number of passes that tick, saturating at all-ones. pass_pulse=1 for exactly one clk after any pass, cleared next edge regardless of frame_tick. Recycled pipes never count as a pass.
- Constraint (stated, not checked): PIPE_SPACING > PIPE_WIDTH+MAX_SPEED, so at most one recycle and one pass occur per tick.
- Arithmetic is signed COORD_W throughout; pipe_x may go negative down to -PIPE_WIDTH.

Optional Feature:
PIPE_SPEED_RAMP_EN defined:
- A pass counter counts passes. On each pass that makes the count a multiple of RAMP_INTERVAL, speed increments, capped at MAX_SPEED.
- The counter clears with score on START_SCREEN and on reset.
- The new speed applies from the next tick.
PIPE_SPEED_RAMP_EN undefined:
- speed is constant BASE_SPEED.
- No counter logic is synthesised.

Test Plan:
- Reset with rst_n low -> pipe_x = 660, 840, 1020, 1200; pipe_y all 210; score 0; speed 1.
- START_SCREEN 3 ticks, then IN_GAME 10 ticks -> pipe_x[0]=650, pipe_x[3]=1190; a tick-free idle of 100 clks changes nothing.
- IN_GAME 5 ticks, PAUSE 20 ticks, IN_GAME 5 ticks -> pipe_x[0]=650, all y unchanged during pause.
- Recycle: pipe_x[0] reaches -78 after 738 ticks; tick 739 -> pipe_x[0]=641 (pipe 3: 462->461, +180), pipe_y[0] in 178..240.
- Scoring: bird_x=100, tick 639 (pipe_x[0] 22->21) -> pass_pulse high exactly one clk, score=1. With PIPE_SPEED_RAMP_EN, after 8 passes speed=2.
- Drop rst_n mid-game between ticks -> outputs take reset values asynchronously before the next clk edge.
